// File: rtl/switch_mcu_alu_rr.sv
// Register-reading ALU unit for OP / OP-IMM instructions: reads rs1/rs2, computes, writes back.
// Optional SWITCH_MCU_SERIAL_SHIFT_EN selects a 1-bit-per-cycle shifter instead of a barrel shifter.
module switch_mcu_alu_rr #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic              in_use_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [11:0]       in_imm_type_i,
  output logic [4:0]        out_raddr_1,
  output logic              out_ren_1,
  input  logic [XLEN-1:0]   in_rdata_1,
  output logic [4:0]        out_raddr_2,
  output logic              out_ren_2,
  input  logic [XLEN-1:0]   in_rdata_2,
  output logic [4:0]        out_waddr,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_wdata,
  output logic              out_busy,
  output logic              out_done
);

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(9);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EX, S_WB} state_t;

  state_t            state;
  logic [OP_W-1:0]   alu_op_q;
  logic              use_imm_q;
  logic [4:0]        rd_q;
  logic [11:0]       imm_q;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   b_next_c;
  logic [XLEN-1:0]   alu_c;
  logic [XLEN-1:0]   sll_c;
  logic [XLEN-1:0]   srl_c;
  logic [XLEN-1:0]   sra_c;

  assign b_next_c = use_imm_q ? {{(XLEN-12){imm_q[11]}}, imm_q} : in_rdata_2;

`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
  logic [4:0]        cnt;
  logic              is_shift_c;
  logic [XLEN-1:0]   step_c;

  // One-bit step per op; a zero shift amount passes op_a through on the final cycle.
  assign sll_c = (cnt == 5'd0) ? op_a : {op_a[XLEN-2:0], 1'b0};
  assign srl_c = (cnt == 5'd0) ? op_a : {1'b0, op_a[XLEN-1:1]};
  assign sra_c = (cnt == 5'd0) ? op_a : {op_a[XLEN-1], op_a[XLEN-1:1]};
  assign is_shift_c = (alu_op_q == ALU_SLL) || (alu_op_q == ALU_SRL) || (alu_op_q == ALU_SRA);

  always_comb begin
    step_c = {op_a[XLEN-2:0], 1'b0};
    if (alu_op_q == ALU_SRL) step_c = {1'b0, op_a[XLEN-1:1]};
    if (alu_op_q == ALU_SRA) step_c = {op_a[XLEN-1], op_a[XLEN-1:1]};
  end
`else
  logic [4:0]        shamt_c;

  assign shamt_c = op_b[4:0];
  assign sll_c   = op_a << shamt_c;
  assign srl_c   = op_a >> shamt_c;
  assign sra_c   = XLEN'($signed(op_a) >>> shamt_c);
`endif

  // Result selection; unused opcodes produce zero.
  always_comb begin
    alu_c = '0;
    case (alu_op_q)
      ALU_ADD:  alu_c = op_a + op_b;
      ALU_SUB:  alu_c = op_a - op_b;
      ALU_SLL:  alu_c = sll_c;
      ALU_SLT:  alu_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_c = XLEN'(op_a < op_b);
      ALU_XOR:  alu_c = op_a ^ op_b;
      ALU_SRL:  alu_c = srl_c;
      ALU_SRA:  alu_c = sra_c;
      ALU_OR:   alu_c = op_a | op_b;
      ALU_AND:  alu_c = op_a & op_b;
      default:  alu_c = '0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state       <= S_IDLE;
      alu_op_q    <= '0;
      use_imm_q   <= 1'b0;
      rd_q        <= '0;
      imm_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
      cnt         <= '0;
`endif
      out_raddr_1 <= '0;
      out_ren_1   <= 1'b0;
      out_raddr_2 <= '0;
      out_ren_2   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      // Read strobes and writeback are single-cycle pulses.
      out_raddr_1 <= '0;
      out_ren_1   <= 1'b0;
      out_raddr_2 <= '0;
      out_ren_2   <= 1'b0;
      out_waddr   <= '0;
      out_wen     <= 1'b0;
      out_wdata   <= '0;
      out_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            alu_op_q    <= in_alu_op;
            use_imm_q   <= in_use_imm;
            rd_q        <= in_rd;
            imm_q       <= in_imm_type_i;
            out_ren_1   <= 1'b1;
            out_raddr_1 <= in_rs1;
            out_ren_2   <= !in_use_imm;
            out_raddr_2 <= in_use_imm ? 5'd0 : in_rs2;
            out_busy    <= 1'b1;
            state       <= S_RD;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          op_a  <= in_rdata_1;
          op_b  <= b_next_c;
`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
          cnt   <= b_next_c[4:0];
`endif
          state <= S_EX;
        end
        S_EX: begin
`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
          if (is_shift_c && (cnt > 5'd1)) begin
            op_a <= step_c;
            cnt  <= cnt - 5'd1;
          end else begin
            out_done  <= 1'b1;
            out_wen   <= (rd_q != 5'd0);
            out_waddr <= rd_q;
            out_wdata <= (rd_q != 5'd0) ? alu_c : '0;
            state     <= S_WB;
          end
`else
          out_done  <= 1'b1;
          out_wen   <= (rd_q != 5'd0);
          out_waddr <= rd_q;
          out_wdata <= (rd_q != 5'd0) ? alu_c : '0;
          state     <= S_WB;
`endif
        end
        S_WB: begin
          out_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          out_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_mcu_alu_rr.sv
// Directed bench for switch_mcu_alu_rr: transaction-level model plus per-cycle output check.
module tb_switch_mcu_alu_rr;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_start = 1'b0;
  logic [3:0]  in_alu_op = '0;
  logic        in_use_imm = 1'b0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [11:0] in_imm_type_i = '0;
  logic [4:0]  out_raddr_1, out_raddr_2, out_waddr;
  logic        out_ren_1, out_ren_2, out_wen, out_busy, out_done;
  logic [31:0] in_rdata_1 = '0, in_rdata_2 = '0, out_wdata;

  switch_mcu_alu_rr dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_alu_op(in_alu_op),
    .in_use_imm(in_use_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm_type_i(in_imm_type_i), .out_raddr_1(out_raddr_1), .out_ren_1(out_ren_1),
    .in_rdata_1(in_rdata_1), .out_raddr_2(out_raddr_2), .out_ren_2(out_ren_2),
    .in_rdata_2(in_rdata_2), .out_waddr(out_waddr), .out_wen(out_wen),
    .out_wdata(out_wdata), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  logic [31:0] rf [32];
  int cyc = 0;
  int nvec = 0;
  int nfail = 0;

  // Model of the in-flight transaction
  bit          mvalid = 1'b0;
  int          mk = 0;
  int          mlat = 0;
  logic [4:0]  mrs1, mrs2, mrd;
  bit          muse;
  logic [31:0] mexp;

  always @(posedge in_clk) cyc <= cyc + 1;

  // Registered-read regfile; x0 reads zero
  always @(posedge in_clk) begin
    if (out_ren_1) in_rdata_1 <= (out_raddr_1 == 5'd0) ? 32'd0 : rf[out_raddr_1];
    if (out_ren_2) in_rdata_2 <= (out_raddr_2 == 5'd0) ? 32'd0 : rf[out_raddr_2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      8: return a | b;
      9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle comparison of every output against the transaction model
  always @(negedge in_clk) begin
    bit rd_ph, wb, act;
    act   = mvalid && (cyc >= mk) && (cyc <= mk + mlat - 1);
    rd_ph = mvalid && (cyc == mk);
    wb    = mvalid && (cyc == mk + mlat - 1);
    chk("busy", 32'(out_busy), 32'(act));
    chk("ren_1", 32'(out_ren_1), 32'(rd_ph));
    chk("ren_2", 32'(out_ren_2), 32'(rd_ph && !muse));
    chk("raddr_1", 32'(out_raddr_1), rd_ph ? 32'(mrs1) : 32'd0);
    chk("raddr_2", 32'(out_raddr_2), (rd_ph && !muse) ? 32'(mrs2) : 32'd0);
    chk("done", 32'(out_done), 32'(wb));
    chk("wen", 32'(out_wen), 32'(wb && (mrd != 5'd0)));
    chk("waddr", 32'(out_waddr), (wb && (mrd != 5'd0)) ? 32'(mrd) : 32'd0);
    chk("wdata", out_wdata, (wb && (mrd != 5'd0)) ? mexp : 32'd0);
  end

  // Advance (posedge + 1) until the model says the unit is back in IDLE
  task automatic wait_idle();
    int guard = 0;
    while (mvalid && (cyc < mk + mlat)) begin
      @(posedge in_clk); #1;
      guard++;
      if (guard > 200) begin
        nfail++;
        $display("FAIL wait_idle timeout cyc=%0d", cyc);
        break;
      end
    end
  endtask

  task automatic issue(input int op, input bit ui, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [11:0] imm,
                       input bit haslit, input logic [31:0] lit);
    logic [31:0] a, b;
    wait_idle();
    a = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    b = ui ? {{20{imm[11]}}, imm} : ((rs2 == 5'd0) ? 32'd0 : rf[rs2]);
    mexp = ref_alu(op, a, b);
    if (haslit) chk("model_lit", mexp, lit);
    mlat = 4;
`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
    if (op == 2 || op == 6 || op == 7) mlat = 3 + ((b[4:0] == 5'd0) ? 1 : int'(b[4:0]));
`endif
    in_alu_op = 4'(op); in_use_imm = ui; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_imm_type_i = imm; in_start = 1'b1;
    mrs1 = rs1; mrs2 = rs2; mrd = rd; muse = ui; mk = cyc + 1; mvalid = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0; in_alu_op = 4'd0; in_use_imm = 1'b0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm_type_i = 12'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h8000_0000;
    rf[5] = 32'd1; rf[6] = 32'hFFFF_FFFF; rf[7] = 32'd4;
    rf[10] = 32'h0F0F_00FF; rf[11] = 32'h00FF_0F0F;

    repeat (3) @(posedge in_clk);
    #1;
    chk("reset_wen", 32'(out_wen), 32'd0);
    chk("reset_busy", 32'(out_busy), 32'd0);
    in_rst = 1'b1;
    @(posedge in_clk); #1;

    // x1+x2 -> x3, and its fixed latency
    issue(0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0, 1'b1, 32'h0000_000C);
    chk("lat_add", 32'(mlat), 32'd4);
    // ADDI x0 + 0xFFF
    issue(0, 1'b1, 5'd0, 5'd0, 5'd8, 12'hFFF, 1'b1, 32'hFFFF_FFFF);
    // SRA x4 by x7 (4)
    issue(7, 1'b0, 5'd4, 5'd7, 5'd9, 12'd0, 1'b1, 32'hF800_0000);
`ifdef SWITCH_MCU_SERIAL_SHIFT_EN
    chk("lat_sra", 32'(mlat), 32'd7);
`else
    chk("lat_sra", 32'(mlat), 32'd4);
`endif
    // SRAI by imm[4:0]=4 with imm[10] set
    issue(7, 1'b1, 5'd4, 5'd0, 5'd9, 12'h404, 1'b1, 32'hF800_0000);
    // Signed vs unsigned compare, and wrapping subtract
    issue(4, 1'b0, 5'd5, 5'd6, 5'd12, 12'd0, 1'b1, 32'd1);
    issue(3, 1'b0, 5'd5, 5'd6, 5'd13, 12'd0, 1'b1, 32'd0);
    issue(1, 1'b0, 5'd0, 5'd5, 5'd14, 12'd0, 1'b1, 32'hFFFF_FFFF);
    // Remaining ops and shift boundaries
    issue(2, 1'b1, 5'd5, 5'd0, 5'd15, 12'd31, 1'b1, 32'h8000_0000);
    issue(2, 1'b1, 5'd6, 5'd0, 5'd15, 12'd0, 1'b1, 32'hFFFF_FFFF);
    issue(6, 1'b0, 5'd6, 5'd7, 5'd16, 12'd0, 1'b1, 32'h0FFF_FFFF);
    issue(5, 1'b0, 5'd10, 5'd11, 5'd17, 12'd0, 1'b1, 32'h0FF0_0FF0);
    issue(8, 1'b0, 5'd10, 5'd11, 5'd18, 12'd0, 1'b1, 32'h0FFF_0FFF);
    issue(9, 1'b1, 5'd10, 5'd0, 5'd19, 12'h0F0, 1'b1, 32'h0000_00F0);
    issue(12, 1'b0, 5'd1, 5'd2, 5'd20, 12'd0, 1'b1, 32'd0);
    issue(3, 1'b1, 5'd6, 5'd0, 5'd21, 12'h000, 1'b1, 32'd1);

    // rd=0 then an immediate back-to-back start
    issue(0, 1'b0, 5'd1, 5'd2, 5'd0, 12'd0, 1'b0, 32'd0);
    issue(0, 1'b0, 5'd2, 5'd2, 5'd22, 12'd0, 1'b1, 32'd14);

    // Start while in CAP is dropped
    issue(0, 1'b0, 5'd1, 5'd1, 5'd23, 12'd0, 1'b1, 32'd10);
    @(posedge in_clk); #1;
    in_start = 1'b1; in_rs1 = 5'd6; in_rd = 5'd24; in_alu_op = 4'd5;
    @(posedge in_clk); #1;
    in_start = 1'b0; in_rs1 = 5'd0; in_rd = 5'd0; in_alu_op = 4'd0;

    // Reset while in EX clears outputs immediately
    issue(0, 1'b0, 5'd1, 5'd2, 5'd25, 12'd0, 1'b0, 32'd0);
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    mvalid = 1'b0;
    #1;
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_wen", 32'(out_wen), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_wdata", out_wdata, 32'd0);
    repeat (2) @(posedge in_clk);
    #1;
    in_rst = 1'b1;
    repeat (4) @(posedge in_clk);
    #1;
    issue(1, 1'b0, 5'd2, 5'd1, 5'd26, 12'd0, 1'b1, 32'd2);

    wait_idle();
    repeat (3) @(posedge in_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
